// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, default timing constants and counter sizing helpers
//
// Contents:
//   spi_state_t    burst sequencer state encoding
//   *_DEF          default ss_n setup/hold/gap and engine timeout in clk cycles
//   max4()         largest of four integers
//   cnt_width()    down-counter width able to hold the largest of four loads

package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_WAIT,
        ST_DONE,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    localparam int SS_SETUP_DEF = 4;
    localparam int SS_HOLD_DEF  = 4;
    localparam int SS_GAP_DEF   = 8;
    localparam int TIMEOUT_DEF  = 4096;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // All parameters at 0 would give a zero-width counter, so clamp to 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int w;
        w = $clog2(max4(a, b, c, d) + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// rtl/spi_rr_arb2.sv - two-way round-robin picker for the SPI bus owner
//
// Ports:
//   req       in  2  pending requests
//   last_gnt  in  1  index of the requester granted most recently
//   pick      out 2  one-hot winner, zero when nobody requests

module spi_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            // Contention: the one that did not go last wins.
            2'b11:   pick = last_gnt ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/spi_master_arb.sv
// rtl/spi_master_arb.sv - two-requester SPI burst arbiter and ss_n/byte-engine sequencer
//
// Ports:
//   clk        in   1   system clock, rising edge
//   btn_reset  in   1   asynchronous active-low reset
//   req        in   2   per-requester burst/byte request (level)
//   last       in   2   per-requester "current byte ends the burst"
//   tx_data    in   16  requester i byte at [8i+7:8i]
//   gnt        out  2   one-hot bus owner for the whole burst
//   done       out  2   one-cycle pulse, owner's byte completed
//   rx_data    out  8   received byte, valid while done is non-zero
//   err        out  1   one-cycle pulse on engine timeout
//   ss_n       out  1   slave select, active-low
//   eng_start  out  1   one-cycle start pulse to the byte engine
//   eng_tx     out  8   byte to transmit, valid with eng_start
//   eng_busy   in   1   engine is shifting
//   eng_done   in   1   one-cycle pulse, byte shifted
//   eng_rx     in   8   received byte, valid with eng_done

module spi_master_arb
    import spi_pkg::*;
#(
    parameter int SS_SETUP_CYC = SS_SETUP_DEF,
    parameter int SS_HOLD_CYC  = SS_HOLD_DEF,
    parameter int SS_GAP_CYC   = SS_GAP_DEF,
    parameter int TIMEOUT_CYC  = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        btn_reset,
    input  logic [1:0]  req,
    input  logic [1:0]  last,
    input  logic [15:0] tx_data,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [7:0]  rx_data,
    output logic        err,
    output logic        ss_n,
    output logic        eng_start,
    output logic [7:0]  eng_tx,
    input  logic        eng_busy,
    input  logic        eng_done,
    input  logic [7:0]  eng_rx
);

    localparam int CW = cnt_width(SS_SETUP_CYC, SS_HOLD_CYC, SS_GAP_CYC, TIMEOUT_CYC);

    spi_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        owner_q;
    logic        last_gnt_q;
    logic        last_q;
    logic [7:0]  rx_q;

    logic [1:0]  pick;
    logic        owner_load;
    logic        rec_owner;
    logic        latch_last;
    logic        capture;
    logic        start_c;
    logic        err_c;
    logic        expired;
    logic        bus_active;
    logic [7:0]  own_byte;

    spi_rr_arb2 u_arb (
        .req      (req),
        .last_gnt (last_gnt_q),
        .pick     (pick)
    );

    // Count value a timed state starts with; a 0 parameter still yields one cycle
    // because the exit test below is "count <= 1".
    function automatic logic [CW-1:0] load_val(input spi_state_t s);
        case (s)
            ST_SETUP: return CW'(SS_SETUP_CYC);
            ST_WAIT:  return CW'(TIMEOUT_CYC);
            ST_HOLD:  return CW'(SS_HOLD_CYC);
            ST_GAP:   return CW'(SS_GAP_CYC);
            default:  return '0;
        endcase
    endfunction

    assign expired  = (cnt_q <= CW'(1));
    assign own_byte = owner_q ? tx_data[15:8] : tx_data[7:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_load = 1'b0;
        rec_owner  = 1'b0;
        latch_last = 1'b0;
        capture    = 1'b0;
        start_c    = 1'b0;
        err_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    owner_load = 1'b1;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Owner gave up before any byte moved: close the frame quietly.
                if (!req[owner_q])   state_d = ST_HOLD;
                else if (expired)    state_d = ST_START;
                else                 cnt_d   = cnt_q - CW'(1);
            end
            ST_START: begin
                if (!eng_busy) begin
                    start_c    = 1'b1;
                    latch_last = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (expired) begin
                    err_c   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                if (!last_q && req[owner_q]) state_d = ST_START;
                else                         state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (expired) begin
                    rec_owner = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (expired) state_d = ST_IDLE;
                else         cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = load_val(state_d);
    end

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;     // "requester 1 went last" gives requester 0 priority
            last_q     <= 1'b0;
            rx_q       <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (owner_load) owner_q    <= pick[1];
            if (rec_owner)  last_gnt_q <= owner_q;
            if (latch_last) last_q     <= last[owner_q];
            if (capture)    rx_q       <= eng_rx;
        end
    end

    // ss_n and gnt follow the state register, so the async reset drops them at once.
    assign bus_active = (state_q != ST_IDLE) && (state_q != ST_GAP);
    assign ss_n       = ~bus_active;
    assign gnt        = bus_active ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign done       = (state_q == ST_DONE) ? gnt : 2'b00;
    assign rx_data    = rx_q;
    assign err        = err_c;
    assign eng_start  = start_c;
    assign eng_tx     = start_c ? own_byte : 8'h00;

endmodule

// File: tb/tb_spi_master_arb.sv
// tb/tb_spi_master_arb.sv - scoreboard bench for spi_master_arb with a simple byte-engine model

module tb_spi_master_arb;

    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int         kind;
        logic [1:0] g;
        logic [7:0] d;
        int         aux;     // start: ss_n-low cycles before it (-1 = skip); err: cycles after start
    } ev_t;

    logic        clk = 1'b0;
    logic        btn_reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  last = 2'b00;
    logic [15:0] tx_data = 16'h0000;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  rx_data;
    logic        err;
    logic        ss_n;
    logic        eng_start;
    logic [7:0]  eng_tx;
    logic        eng_busy = 1'b0;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_rx = 8'h00;

    int   tests = 0;
    int   fails = 0;
    ev_t  exp_q[$];
    logic [7:0] rsp_q[$];
    bit   eng_auto = 1'b1;
    bit   kick = 1'b0;

    spi_master_arb dut (
        .clk       (clk),
        .btn_reset (btn_reset),
        .req       (req),
        .last      (last),
        .tx_data   (tx_data),
        .gnt       (gnt),
        .done      (done),
        .rx_data   (rx_data),
        .err       (err),
        .ss_n      (ss_n),
        .eng_start (eng_start),
        .eng_tx    (eng_tx),
        .eng_busy  (eng_busy),
        .eng_done  (eng_done),
        .eng_rx    (eng_rx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic void push(input int k, input logic [1:0] g, input logic [7:0] d, input int aux);
        ev_t e;
        e.kind = k; e.g = g; e.d = d; e.aux = aux;
        exp_q.push_back(e);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ss_low(input int lim);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (!ss_n) break;
            n++;
            if (n >= lim) begin flag("timeout_ss_low"); break; end
        end
    endtask

    task automatic wait_start(input int lim);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (eng_start) break;
            n++;
            if (n >= lim) begin flag("timeout_eng_start"); break; end
        end
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n >= lim) begin
                $display("FAIL timeout_drain: %0d events still expected", exp_q.size());
                tests++; fails++;
                exp_q.delete();
                break;
            end
        end
    endtask

    // Byte engine: answers an eng_start seen in one cycle with eng_done in the next.
    task automatic engine();
        bit seen;
        forever begin
            @(negedge clk);
            seen = eng_start;
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (((seen && eng_auto) || kick) && rsp_q.size() > 0) begin
                eng_done = 1'b1;
                eng_rx   = rsp_q.pop_front();
                kick     = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        ev_t e;
        int low_run = 0, high_run = 0, since_end = 0, since_start = 0;
        bit end_seen = 0, rise_seen = 0, prev_ss = 1;
        logic [1:0] bgnt = 2'b00;
        forever begin
            @(negedge clk);
            if (!btn_reset) begin
                low_run = 0; high_run = 0; since_end = 0; since_start = 0;
                end_seen = 0; rise_seen = 0; prev_ss = 1;
            end else begin
                if (!ss_n && prev_ss) begin
                    if (rise_seen && high_run < 9) chk("gap_cycles_min", high_run, 9);
                    bgnt = gnt;
                    chk("gnt_onehot", $countones(bgnt), 1);
                    low_run = 0; end_seen = 0;
                end
                if (ss_n && !prev_ss) begin
                    if (end_seen) chk("hold_cycles", since_end, 4);
                    rise_seen = 1; high_run = 0;
                end
                if (ss_n) chk("gnt_when_ss_high", 32'(gnt), 0);
                else      chk("gnt_locked", 32'(gnt), 32'(bgnt));

                if (eng_start) begin
                    chk("start_not_busy", 32'(eng_busy), 0);
                    if (exp_q.size() == 0) flag("unexpected_eng_start");
                    else begin
                        e = exp_q.pop_front();
                        chk("sb_kind_start", e.kind, K_START);
                        chk("start_gnt", 32'(gnt), 32'(e.g));
                        chk("eng_tx", 32'(eng_tx), 32'(e.d));
                        if (e.aux >= 0) chk("setup_cycles", low_run, e.aux);
                    end
                    since_start = 0;
                end
                if (done != 2'b00) begin
                    if (exp_q.size() == 0) flag("unexpected_done");
                    else begin
                        e = exp_q.pop_front();
                        chk("sb_kind_done", e.kind, K_DONE);
                        chk("done_vec", 32'(done), 32'(e.g));
                        chk("rx_data", 32'(rx_data), 32'(e.d));
                    end
                    end_seen = 1;
                end
                if (err) begin
                    if (exp_q.size() == 0) flag("unexpected_err");
                    else begin
                        e = exp_q.pop_front();
                        chk("sb_kind_err", e.kind, K_ERR);
                        chk("err_delay", since_start, e.aux);
                    end
                    end_seen = 1;
                end

                if (!ss_n) low_run++; else high_run++;
                since_start++;
                if (done != 2'b00 || err) since_end = 0;
                else if (!ss_n) since_end++;
                prev_ss = ss_n;
            end
        end
    endtask

    task automatic pulse_reset();
        cyc(1); btn_reset = 1'b0;
        cyc(1); btn_reset = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            engine();
        join_none

        #2 btn_reset = 1'b0;
        @(negedge clk);
        chk("rst_ss_n", 32'(ss_n), 1);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_eng_tx", 32'(eng_tx), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        cyc(1); btn_reset = 1'b1;

        // Single-byte burst from requester 0.
        rsp_q.push_back(8'h3C);
        push(K_START, 2'b01, 8'hA5, 4);
        push(K_DONE,  2'b01, 8'h3C, 0);
        last = 2'b01; tx_data = 16'h00A5; req = 2'b01;
        wait_ss_low(5);
        wait_start(20);
        cyc(1); req = 2'b00;
        wait_drain(30);
        cyc(20);

        // Both requesting from reset: strict alternation starting with requester 0.
        pulse_reset();
        tx_data = 16'h2211; last = 2'b11;
        for (int i = 0; i < 4; i++) begin
            rsp_q.push_back(8'h50 + 8'(i));
            push(K_START, (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 8'h11 : 8'h22, 4);
            push(K_DONE,  (i % 2 == 0) ? 2'b01 : 2'b10, 8'h50 + 8'(i), 0);
        end
        req = 2'b11;
        wait_drain(300);
        cyc(1); req = 2'b00;
        cyc(20);

        // Requester 1 three-byte burst while requester 0 waits.
        tx_data = 16'h8177; last = 2'b01;
        for (int i = 0; i < 3; i++) begin
            rsp_q.push_back(8'h91 + 8'(i));
            push(K_START, 2'b10, 8'h81 + 8'(i), (i == 0) ? 4 : -1);
            push(K_DONE,  2'b10, 8'h91 + 8'(i), 0);
        end
        rsp_q.push_back(8'h94);
        push(K_START, 2'b01, 8'h77, 4);
        push(K_DONE,  2'b01, 8'h94, 0);
        req = 2'b10;
        wait_ss_low(5);
        cyc(1); req = 2'b11;
        for (int b = 0; b < 3; b++) begin
            wait_start(30);
            cyc(1);
            if (b < 2) tx_data[15:8] = 8'h82 + 8'(b);
            if (b == 1) last[1] = 1'b1;
            if (b == 2) req[1] = 1'b0;
        end
        wait_drain(100);
        req = 2'b00;
        cyc(20);

        // Engine busy when START is entered: two stall cycles.
        eng_busy = 1'b1; tx_data = 16'h00C3; last = 2'b01; req = 2'b01;
        rsp_q.push_back(8'hE1);
        push(K_START, 2'b01, 8'hC3, 6);
        push(K_DONE,  2'b01, 8'hE1, 0);
        wait_ss_low(30);
        repeat (6) @(posedge clk);
        #1 eng_busy = 1'b0;
        wait_start(10);
        cyc(1); req = 2'b00;
        wait_drain(30);
        cyc(20);

        // Engine never answers: timeout error, no done.
        eng_auto = 1'b0; tx_data = 16'h005A; req = 2'b01;
        push(K_START, 2'b01, 8'h5A, 4);
        push(K_ERR,   2'b01, 8'h00, 4096);
        wait_start(30);
        cyc(1); req = 2'b00;
        wait_drain(5000);
        cyc(20);
        chk("timeout_ss_n_high", 32'(ss_n), 1);

        // Reset while waiting on the engine; a late eng_done must be ignored.
        req = 2'b01;
        push(K_START, 2'b01, 8'h5A, 4);
        wait_start(30);
        cyc(1);
        btn_reset = 1'b0;
        #1;
        chk("midrst_ss_n", 32'(ss_n), 1);
        chk("midrst_gnt", 32'(gnt), 0);
        req = 2'b00;
        cyc(1); btn_reset = 1'b1;
        rsp_q.push_back(8'hEE);
        kick = 1'b1;
        cyc(6);
        chk("late_done_rx_hold", 32'(rx_data), 0);
        eng_auto = 1'b1;

        // Request withdrawn during SETUP: frame closes with no engine activity.
        req = 2'b01;
        wait_ss_low(5);
        cyc(1); req = 2'b00;
        cyc(15);
        chk("abort_ss_n", 32'(ss_n), 1);
        chk("abort_gnt", 32'(gnt), 0);

        cyc(2);
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master_arb.md
SPI_MASTER_ARB -- requirements
Module: spi_master_arb

Interface
REQ-001 Parameter SS_SETUP_CYC, default 4: clk cycles ss_n is held low before the first byte of a burst.
REQ-002 Parameter SS_HOLD_CYC, default 4: clk cycles ss_n is held low after the last byte of a burst.
REQ-003 Parameter SS_GAP_CYC, default 8: minimum clk cycles ss_n is high between bursts.
REQ-004 Parameter TIMEOUT_CYC, default 4096: maximum clk cycles to wait for eng_done.
REQ-005 clk  in  1  system clock, all logic on the rising edge.
REQ-006 btn_reset  in  1  reset, asynchronous, active-low.
REQ-007 req  in  2  per-requester burst/byte request, level.
REQ-008 last  in  2  per-requester flag: the current byte ends the burst.
REQ-009 tx_data  in  16  requester i byte at bits [8i+7:8i].
REQ-010 gnt  out  2  one-hot owner of the SPI bus for the whole burst.
REQ-011 done  out  2  one-cycle pulse: owner's byte completed.
REQ-012 rx_data  out  8  received byte, valid while done is non-zero.
REQ-013 err  out  1  one-cycle pulse on engine timeout.
REQ-014 ss_n  out  1  slave select, active-low.
REQ-015 eng_start  out  1  one-cycle start pulse to the SPI byte engine.
REQ-016 eng_tx  out  8  byte to transmit, valid with eng_start.
REQ-017 eng_busy  in  1  engine is shifting.
REQ-018 eng_done  in  1  one-cycle pulse: byte shifted.
REQ-019 eng_rx  in  8  byte received, valid with eng_done.

Function
REQ-020 FSM states: IDLE, SETUP, START, WAIT, DONE, HOLD, GAP.
REQ-021 IDLE: ss_n=1, gnt=0; if req!=0, select owner, go to SETUP, and in the same transition set gnt[owner]=1 and ss_n=0.
REQ-022 Selection: single requester wins; both requesting -> the requester not granted most recently; after reset requester 0 has priority.
REQ-023 SETUP: count SS_SETUP_CYC cycles, then go to START; if req[owner] drops during SETUP, go to HOLD with no engine start and no done.
REQ-024 START: while eng_busy=1, stall; else drive eng_start=1 for exactly one cycle with eng_tx=tx_data byte of owner, latch last[owner], go to WAIT.
REQ-025 WAIT: on eng_done, capture eng_rx into rx_data and go to DONE; if TIMEOUT_CYC cycles elapse with no eng_done, pulse err for one cycle, assert no done, go to HOLD.
REQ-026 DONE (one cycle): done[owner]=1; if latched last=0 and req[owner]=1, go to START; otherwise go to HOLD.
REQ-027 HOLD: ss_n=0 for SS_HOLD_CYC cycles; on exit set ss_n=1 and gnt=0, record owner as most recently granted, go to GAP.
REQ-028 GAP: ss_n=1 for SS_GAP_CYC cycles, requests ignored, then go to IDLE.
REQ-029 Ownership is locked for the full burst; the other requester's req has no effect until IDLE.
REQ-030 eng_done outside WAIT is ignored; rx_data holds its last captured value.
REQ-031 Counters are sized to ceil(log2(max(SS_SETUP_CYC, SS_HOLD_CYC, SS_GAP_CYC, TIMEOUT_CYC)+1)) bits, count down, and are loaded on state entry.
REQ-032 A parameter value of 0 makes the corresponding state last exactly 1 cycle.

Reset
REQ-033 btn_reset=0 immediately forces state=IDLE, ss_n=1, gnt=0, done=0, err=0, eng_start=0, eng_tx=0, rx_data=0, counters=0, priority to requester 0; this applies mid-burst, and no done is issued for an aborted byte.
REQ-034 After btn_reset is released, the first arbitration occurs on the first rising clk edge.

Structure
REQ-035 A shared package spi_pkg holds the state enumeration and the default SS_SETUP/SS_HOLD/SS_GAP/TIMEOUT constants.
REQ-036 Round-robin selection is implemented as one sub-module, spi_rr_arb2 (inputs: req, last-granted; output: one-hot pick); all other logic is in spi_master_arb.

Verification
REQ-037 req=01, last=01, tx_data[7:0]=8'hA5, engine returns 8'h3C -> ss_n low 4 cycles before eng_start, eng_tx=A5, done=01 with rx_data=3C, ss_n high 4 cycles after DONE, then 8 gap cycles.
REQ-038 Both req asserted from reset, 1-byte bursts -> gnt order 01,10,01,10 with no overlap of ss_n low periods.
REQ-039 Requester 1 sends a 3-byte burst (last=1 on the third byte) while req[0] is held high -> ss_n stays low across all 3 bytes, gnt=10 is held throughout, 3 done[1] pulses occur, and gnt=01 follows.
REQ-040 eng_done never arrives -> err pulses exactly 4096 cycles after eng_start, done stays 0, ss_n returns high after HOLD.
REQ-041 btn_reset=0 during WAIT -> same cycle ss_n=1, gnt=0; a later eng_done yields no done.
REQ-042 eng_busy=1 when START is entered -> eng_start is delayed until the cycle after eng_busy falls.
